// File: rtl/fixed_point_squarer.sv
// Unsigned 8.8 fixed-point squarer: sequential shift-add multiply, one multiplier
// bit per clock, with a saturated 8-bit integer part for round-trip checks against sqrt.
module fixed_point_squarer #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   out_sq,
    output logic [7:0]           out_int,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // a producer holds valid and its data stable until that edge.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_sq;
    logic [7:0]           r_int;
    logic                 r_ovf;

    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_sum;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_ovf;
    logic [7:0]           w_int;

    assign w_addend = r_mplier[r_count] ? ({{WIDTH{1'b0}}, r_mcand} << r_count) : '0;
    assign w_sum    = r_acc + w_addend;
    assign w_last   = (r_count == CW'(WIDTH - 1));
    assign w_accept = in_valid && (r_state == S_IDLE);

    // Anything at or above 2^8 in the integer part saturates the 8-bit view.
    assign w_ovf = |w_sum[2*WIDTH-1:2*FRAC+8];
    assign w_int = w_ovf ? 8'hFF : w_sum[2*FRAC+7:2*FRAC];

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = S_BUSY;
            end
            S_BUSY: begin
                if (w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_sq     <= '0;
            r_int    <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= in_data;
            r_mplier <= in_data;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc   <= w_sum;
            r_count <= r_count + 1'b1;
            if (w_last) begin
                r_sq  <= w_sum;
                r_int <= w_int;
                r_ovf <= w_ovf;
            end
        end
    end

    assign out_sq    = r_sq;
    assign out_int   = r_int;
    assign out_ovf   = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: doc/fixed_point_squarer.md
Name: fixed_point_squarer

Overview:
- Inverse companion to the 8-bit integer square-root unit: takes an unsigned 8.8 fixed-point value and returns its square.
- Also returns a saturated 8-bit integer part, so a value → root → square round trip can be checked against the original 8-bit input.
- Sequential shift-add multiplier, one multiplier bit per clock, valid/ready handshake on both sides.
- Sits downstream of the square-root stage in the baggage-weight datapath.

Parameters:
- WIDTH, 16, input operand width in bits (unsigned fixed point).
- FRAC, 8, number of fractional bits in the input; the product carries 2*FRAC fractional bits.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  operand, unsigned 8.8
- in_valid  input  1  operand present
- in_ready  output  1  block can accept an operand
- out_sq  output  2*WIDTH  full square, unsigned 16.16
- out_int  output  8  integer part of square, saturated to 255
- out_ovf  output  1  integer part of square exceeds 255
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result

Behaviour:
- One clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sq=0, out_int=0, out_ovf=0, internal accumulator/counter/operand registers=0.
- Reset asserted mid-operation aborts the operation immediately: no partial result is ever presented, and the block returns to IDLE.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data into the multiplicand and multiplier registers, clear the accumulator, set count=0, go to BUSY.
  - BUSY: in_ready=0. Each edge: if multiplier bit[count] is 1, acc += multiplicand << count. Then count++. The edge that processes count=WIDTH-1 loads out_sq/out_int/out_ovf from the final sum and moves to DONE.
  - DONE: out_valid=1, in_ready=0. Outputs stay stable while out_valid=1 && out_ready=0. On out_ready=1, go to IDLE and clear out_valid on that edge.
- Latency: exactly WIDTH (16) clock edges from the accept edge to the edge where out_valid rises. Throughput: one result per WIDTH+2 cycles minimum.
- No new operand is accepted in the cycle out_valid drops; in_ready rises the cycle after, in IDLE.
- in_data changes while BUSY are ignored; the latched operand is used.
- Arithmetic:
  - The accumulator is 2*WIDTH bits and cannot overflow, since (2^WIDTH-1)^2 < 2^(2*WIDTH).
  - out_sq is the exact product, no rounding.
  - out_ovf = |out_sq[2*WIDTH-1 : 2*FRAC+8].
  - out_int = out_ovf ? 8'hFF : out_sq[2*FRAC+7 : 2*FRAC], i.e. the integer part truncated toward zero.
- Zero operand: still runs the full WIDTH cycles; result 0, out_ovf=0.
- in_valid held high continuously: one operand accepted per IDLE visit, no duplicate accept.
- out_ready held high: DONE lasts exactly one cycle.

Test Plan:
- Reset, then in_data=16'h0100 (1.0) with in_valid pulse → out_valid rises 16 edges after accept; out_sq=32'h0001_0000, out_int=1, out_ovf=0.
- in_data=16'h016A (1.4140625) → out_sq=32'h0001_FFE4, out_int=1, out_ovf=0. This confirms that truncation never exceeds the sqrt source value 2.
- in_data=16'h0F00 (15.0) → out_sq=32'h00E1_0000, out_int=8'hE1, out_ovf=0. Then in_data=16'h1000 (16.0) → out_sq=32'h0100_0000, out_int=8'hFF, out_ovf=1.
- in_data=16'hFFFF → out_sq=32'hFFFE_0001, out_int=8'hFF, out_ovf=1. Also in_data=0 → out_sq=0 after 16 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid and all outputs stable, in_ready=0, in_valid ignored. Then out_ready=1 → out_valid falls next edge and in_ready=1 the same edge.
- Assert rst at BUSY count=7, release → out_valid=0, in_ready=1, outputs 0. Then a new operand 16'h0200 → out_sq=32'h0004_0000 with no contamination from the aborted run.
